// File: rtl/idstage_pkg.sv
// Shared decode-stage definitions: immediate modes,
// instruction field positions, NOP encoding and immediate helper.
package idstage_pkg;

    typedef enum logic [1:0] {
        IMM_SEXT     = 2'b00,
        IMM_ZFILL    = 2'b01,
        IMM_LUI      = 2'b10,
        IMM_SEXT_SH2 = 2'b11
    } imm_mode_e;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] imm_extend(
        input logic [15:0] imm,
        input imm_mode_e   mode
    );
        logic [31:0] sx;
        logic [31:0] res;
        sx  = {{16{imm[15]}}, imm};
        res = sx;
        unique case (mode)
            IMM_SEXT:     res = sx;
            IMM_ZFILL:    res = {16'h0000, imm};
            IMM_LUI:      res = {imm, 16'h0000};
            IMM_SEXT_SH2: res = {sx[29:0], 2'b00};
            default:      res = sx;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/idstage_register_file.sv
// 2R/1W register file, R0 hardwired to zero,
// same-cycle write-to-read bypass on both read ports.
module register_file #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int AW     = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs [REG_N];

    // Storage: cleared by reset, R0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: R0 reads zero, a live write to the address forwards.
    always_comb begin
        ra_data = regs[ra_addr];
        rb_data = regs[rb_addr];
        if (ra_addr == '0) begin
            ra_data = '0;
        end else if (rst_n && wr_en && (wr_addr == ra_addr)) begin
            ra_data = wr_data;
        end
        if (rb_addr == '0) begin
            rb_data = '0;
        end else if (rst_n && wr_en && (wr_addr == rb_addr)) begin
            rb_data = wr_data;
        end
    end

endmodule

// File: rtl/idstage.sv
// Instruction decode stage: IF/ID register, operand read,
// immediate extension and opcode/func field extraction.
module idstage
    import idstage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [31:0]              Instr,
    input  logic                     If_Valid,
    input  logic                     Stall,
    input  logic                     Flush,
    input  logic                     RF_WrEn,
    input  logic [$clog2(REG_N)-1:0] RF_WrAddr,
    input  logic [DATA_W-1:0]        RF_WrData,
    input  logic                     RF_B_sel,
    input  logic [1:0]               ImmExt,
    output logic                     Id_Valid,
    output logic [5:0]               Opcode,
    output logic [5:0]               Func,
    output logic [DATA_W-1:0]        RF_A,
    output logic [DATA_W-1:0]        RF_B,
    output logic [DATA_W-1:0]        Immed
);

    localparam int AW = $clog2(REG_N);

    logic [31:0]   ir;
    logic          v;
    logic [AW-1:0] rb_addr;

    // IF/ID register: flush beats stall beats load.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ir <= NOP;
            v  <= 1'b0;
        end else if (Flush) begin
            ir <= NOP;
            v  <= 1'b0;
        end else if (!Stall) begin
            ir <= Instr;
            v  <= If_Valid;
        end
    end

    // Field decode and immediate extension straight from IR.
    always_comb begin
        Id_Valid = v;
        Opcode   = ir[OPC_MSB:OPC_LSB];
        Func     = ir[FUNC_MSB:FUNC_LSB];
        rb_addr  = RF_B_sel ? ir[RT_MSB:RT_LSB] : ir[RD_MSB:RD_LSB];
        Immed    = DATA_W'(imm_extend(ir[IMM_MSB:IMM_LSB],
                                      imm_mode_e'(ImmExt)));
    end

    register_file #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_rf (
        .clk     (Clk),
        .rst_n   (Reset),
        .wr_en   (RF_WrEn),
        .wr_addr (RF_WrAddr),
        .wr_data (RF_WrData),
        .ra_addr (ir[RS_MSB:RS_LSB]),
        .ra_data (RF_A),
        .rb_addr (rb_addr),
        .rb_data (RF_B)
    );

endmodule

// File: tb/tb_idstage.sv
// Self-checking bench for idstage: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_idstage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic        If_Valid;
    logic        Stall;
    logic        Flush;
    logic        RF_WrEn;
    logic [4:0]  RF_WrAddr;
    logic [31:0] RF_WrData;
    logic        RF_B_sel;
    logic [1:0]  ImmExt;
    logic        Id_Valid;
    logic [5:0]  Opcode;
    logic [5:0]  Func;
    logic [31:0] RF_A;
    logic [31:0] RF_B;
    logic [31:0] Immed;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_ir;
    logic        m_v;

    idstage dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Instr     (Instr),
        .If_Valid  (If_Valid),
        .Stall     (Stall),
        .Flush     (Flush),
        .RF_WrEn   (RF_WrEn),
        .RF_WrAddr (RF_WrAddr),
        .RF_WrData (RF_WrData),
        .RF_B_sel  (RF_B_sel),
        .ImmExt    (ImmExt),
        .Id_Valid  (Id_Valid),
        .Opcode    (Opcode),
        .Func      (Func),
        .RF_A      (RF_A),
        .RF_B      (RF_B),
        .Immed     (Immed)
    );

    initial forever #5 Clk = ~Clk;

    function automatic logic [31:0] exp_read(input int a);
        if (a == 0) return 32'h0;
        if (Reset && RF_WrEn && int'(RF_WrAddr) == a) return RF_WrData;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] ir,
                                            input int mode);
        int s;
        int u;
        u = int'(ir & 32'h0000_FFFF);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            0: return 32'(s);
            1: return 32'(u);
            2: return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_ir = 32'h0;
        m_v  = 1'b0;
    endfunction

    // Advance one clock and move the model with it.
    task automatic tick();
        @(posedge Clk);
        if (Reset) begin
            if (RF_WrEn && RF_WrAddr != 5'd0) m_regs[RF_WrAddr] = RF_WrData;
            if (Flush) begin
                m_ir = 32'h0;
                m_v  = 1'b0;
            end else if (!Stall) begin
                m_ir = Instr;
                m_v  = If_Valid;
            end
        end else begin
            model_clear();
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Instr = 32'hFFFF_FFFF; If_Valid = 1'b1;
        Stall = 0; Flush = 0; RF_WrEn = 0; RF_WrAddr = 0;
        RF_WrData = 0; RF_B_sel = 0; ImmExt = 0;
        model_clear();
        repeat (3) tick();
        checks++;
        if (Id_Valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", Id_Valid);
        end
        checks++;
        if (Opcode !== 6'h0 || Func !== 6'h0) begin
            errors++; $display("FAIL reset_fields got %h/%h want 0/0", Opcode, Func);
        end
        checks++;
        if (RF_A !== 32'h0 || RF_B !== 32'h0) begin
            errors++; $display("FAIL reset_rf got %h/%h want 0/0", RF_A, RF_B);
        end
        for (int m = 0; m < 4; m++) begin
            ImmExt = 2'(m); #1;
            checks++;
            if (Immed !== 32'h0) begin
                errors++; $display("FAIL reset_imm%0d got %h want 0", m, Immed);
            end
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (Opcode !== 6'h3F || Id_Valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got %h/%b want 3f/1", Opcode, Id_Valid);
        end
    endtask

    task automatic test_write_read();
        RF_WrEn = 1; RF_WrAddr = 5'd5; RF_WrData = 32'hDEAD_BEEF;
        Instr = 32'h00A0_0000; If_Valid = 1;
        tick();
        RF_WrEn = 0; #1;
        checks++;
        if (RF_A !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_rd_r5 got %h want deadbeef", RF_A);
        end
        RF_WrEn = 1; RF_WrAddr = 5'd0; RF_WrData = 32'h1234;
        Instr = 32'h0000_0000;
        tick();
        #1;
        checks++;
        if (RF_A !== 32'h0) begin
            errors++; $display("FAIL wr_r0_bypass got %h want 0", RF_A);
        end
        RF_WrEn = 0;
        tick();
        checks++;
        if (RF_A !== 32'h0 || RF_B !== 32'h0) begin
            errors++; $display("FAIL wr_r0_store got %h/%h want 0/0", RF_A, RF_B);
        end
    endtask

    task automatic test_bypass();
        RF_B_sel = 1; Instr = 32'h0007_0000; If_Valid = 1;
        tick();
        RF_WrEn = 1; RF_WrAddr = 5'd7; RF_WrData = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (RF_B !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL bypass_b got %h want a5a5a5a5", RF_B);
        end
        tick();
        RF_WrEn = 0; #1;
        checks++;
        if (RF_B !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL bypass_store got %h want a5a5a5a5", RF_B);
        end
        RF_B_sel = 0; #1;
        checks++;
        if (RF_B !== 32'h0) begin
            errors++; $display("FAIL bsel_rd got %h want 0", RF_B);
        end
    endtask

    task automatic test_imm();
        logic [31:0] want [4];
        want[0] = 32'hFFFF_FFFC; want[1] = 32'h0000_FFFC;
        want[2] = 32'hFFFC_0000; want[3] = 32'hFFFF_FFF0;
        Instr = 32'h1234_FFFC;
        tick();
        for (int m = 0; m < 4; m++) begin
            ImmExt = 2'(m); #1;
            checks++;
            if (Immed !== want[m]) begin
                errors++;
                $display("FAIL imm_mode%0d got %h want %h", m, Immed, want[m]);
            end
        end
    endtask

    task automatic test_stall_flush();
        Instr = 32'h2041_0005; If_Valid = 1; Stall = 0; Flush = 0;
        tick();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            Instr = $urandom; If_Valid = 1'($urandom);
            tick();
            checks++;
            if (Opcode !== 6'h08 || Func !== 6'h05 || Id_Valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got %h/%h/%b want 08/05/1",
                         i, Opcode, Func, Id_Valid);
            end
        end
        Flush = 1;
        tick();
        ImmExt = 2'd0; #1;
        checks++;
        if (Opcode !== 6'h0 || Func !== 6'h0 || Id_Valid !== 1'b0
            || Immed !== 32'h0) begin
            errors++;
            $display("FAIL flush_wins got %h/%h/%b/%h want 0/0/0/0",
                     Opcode, Func, Id_Valid, Immed);
        end
        Stall = 0; Flush = 0;
    endtask

    task automatic test_async_reset();
        RF_WrEn = 1; RF_WrAddr = 5'd3; RF_WrData = 32'h55;
        Instr = 32'h0060_0000; If_Valid = 1;
        tick();
        RF_WrEn = 0; #1;
        checks++;
        if (RF_A !== 32'h55) begin
            errors++; $display("FAIL pre_areset got %h want 55", RF_A);
        end
        #1 Reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (RF_A !== 32'h0 || Id_Valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h/%b want 0/0", RF_A, Id_Valid);
        end
        #1 Reset = 1'b1;
        #1;
        checks++;
        if (RF_A !== 32'h0 || Opcode !== 6'h0) begin
            errors++;
            $display("FAIL post_areset got %h/%h want 0/0", RF_A, Opcode);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            Instr     = $urandom;
            If_Valid  = 1'($urandom);
            Stall     = ($urandom_range(0, 4) == 0);
            Flush     = ($urandom_range(0, 7) == 0);
            RF_WrEn   = 1'($urandom);
            RF_WrAddr = ($urandom_range(0, 2) == 0) ? m_ir[25:21] : 5'($urandom);
            RF_WrData = $urandom;
            RF_B_sel  = 1'($urandom);
            ImmExt    = 2'($urandom);
            #1;
            checks++;
            if (Id_Valid !== m_v || Opcode !== m_ir[31:26]
                || Func !== m_ir[5:0]) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rnd_ctl%0d got %b/%h/%h want %b/%h/%h",
                             n, Id_Valid, Opcode, Func,
                             m_v, m_ir[31:26], m_ir[5:0]);
            end
            checks++;
            if (RF_A !== exp_read(int'(m_ir[25:21]))) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rnd_rfa%0d got %h want %h",
                             n, RF_A, exp_read(int'(m_ir[25:21])));
            end
            checks++;
            if (RF_B !== exp_read(RF_B_sel ? int'(m_ir[20:16])
                                           : int'(m_ir[15:11]))) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rnd_rfb%0d got %h want %h", n, RF_B,
                             exp_read(RF_B_sel ? int'(m_ir[20:16])
                                               : int'(m_ir[15:11])));
            end
            checks++;
            if (Immed !== exp_imm(m_ir, int'(ImmExt))) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rnd_imm%0d got %h want %h",
                             n, Immed, exp_imm(m_ir, int'(ImmExt)));
            end
            tick();
        end
        Stall = 0; Flush = 0; RF_WrEn = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_imm();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idstage.md
# idstage

Instruction-decode stage directly downstream of the instruction-fetch stage. It latches each fetched instruction into an IF/ID pipeline register and reads two operands from a 32×32 register file with write-through bypass. It also produces the extended immediate and the opcode/func fields consumed by the execute stage and control unit. Register-file writes arrive from the writeback stage.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- REG_N, 32, number of architectural registers (address width 5)

Ports:
- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- Instr  in  32  instruction from fetch stage
- If_Valid  in  1  Instr is a real instruction this cycle
- Stall  in  1  hold IF/ID register contents
- Flush  in  1  squash IF/ID register (branch taken)
- RF_WrEn  in  1  writeback enable
- RF_WrAddr  in  5  writeback register
- RF_WrData  in  32  writeback data
- RF_B_sel  in  1  0: port B reads Instr[15:11]; 1: reads Instr[20:16]
- ImmExt  in  2  immediate mode (see Operation)
- Id_Valid  out  1  decoded instruction valid
- Opcode  out  6  IR[31:26]
- Func  out  6  IR[5:0]
- RF_A  out  32  register IR[25:21]
- RF_B  out  32  register selected by RF_B_sel
- Immed  out  32  extended immediate

## Operation
- IR = IF/ID instruction register; V = its valid bit.
- IR update priority at each edge: Reset > Flush > Stall > load.
  - Flush: IR←0, V←0.
  - Stall: hold IR and V.
  - Otherwise: IR←Instr, V←If_Valid.
- Id_Valid = V. Opcode, Func, RF_A, RF_B and Immed are combinational from IR.
- Register file:
  - R0 reads 0 always; writes to R0 are ignored.
  - A write occurs on the edge when RF_WrEn=1. It is independent of Stall and Flush.
- Bypass: a read address equal to RF_WrAddr (nonzero) with RF_WrEn=1 returns RF_WrData in the same cycle.
- ImmExt, from IR[15:0]:
  - 00: sign-extend
  - 01: zero-fill upper 16
  - 10: IR[15:0]<<16
  - 11: sign-extend then <<2; upper bits are discarded, result is 32-bit.
- Register-file reads are performed regardless of V. Consumers must gate on Id_Valid.

## Timing
- Reset values: IR=0, V=0, every register=0. Resulting outputs: Id_Valid=0, Opcode=0, Func=0, RF_A=0, RF_B=0, Immed=0 (for any ImmExt).
- Reset asserted mid-operation clears IR, V and the register file immediately, without waiting for a clock. A write presented during Reset is lost.
- Latency:
  - Instr to Opcode/Func/Immed: 1 cycle.
  - Instr to RF_A/RF_B: 1 cycle plus combinational read.
- Writeback to read: 0 cycles through the bypass; the value is also visible from storage on the following cycle.
- Flush and Stall asserted together: Flush wins.
- Stall held N cycles: outputs remain stable for N cycles. Exception: RF_A/RF_B change if the addressed register is written.
- Simultaneous write to Rk and read of Rk: the read returns the new data.

## Structure
- Shared package/header holds:
  - ImmExt encodings (IMM_SEXT, IMM_ZFILL, IMM_LUI, IMM_SEXT_SH2)
  - instruction field bit positions
  - the NOP encoding (all-zero)
- Sub-module register_file (two async read ports, one sync write port, bypass, R0 hardwired). idstage owns IR/V and the immediate logic.

## Test plan
- Reset: hold Reset=0 with Instr=0xFFFFFFFF, If_Valid=1 and clock running → Id_Valid=0 and all outputs 0. After release, next edge → Opcode=0x3F, Id_Valid=1.
- Write then read: RF_WrEn=1, RF_WrAddr=5, RF_WrData=0xDEADBEEF; load Instr with IR[25:21]=5 → RF_A=0xDEADBEEF. Write R0=0x1234 → reads 0.
- Bypass: in the same cycle, write R7=0xA5A5A5A5 while IR reads R7 on port B (RF_B_sel=1, IR[20:16]=7) → RF_B=0xA5A5A5A5 before the edge.
- Immediate with IR[15:0]=0xFFFC: ImmExt 00 → 0xFFFFFFFC; 01 → 0x0000FFFC; 10 → 0xFFFC0000; 11 → 0xFFFFFFF0.
- Stall/Flush: load 0x20410005, then Stall=1 for 3 cycles while Instr changes → IR unchanged. Then Stall=1 and Flush=1 → IR=0, Id_Valid=0.
- Async reset mid-stream: after writing R3=0x55, pulse Reset=0 between clock edges → RF_A for R3 reads 0 immediately and Id_Valid=0.
